imm_extend_pipe: RTL
====================

Name: imm_extend_pipe

Overview:
- Parametrised immediate-extension unit that succeeds the fixed 16→32 sign extender.
- Supports four extension modes: sign, zero, upper and branch-offset.
- Results are buffered in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Sits between the decode stage and the ALU operand mux in the pipelined datapath; absorbs one or more cycles of downstream stall without losing immediates.

Parameters:
- IN_W, 16: immediate input width; legal range 1..OUT_W.
- OUT_W, 32: extended output width.
- DEPTH, 2: FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-high
- in_valid  in  1  producer presents an immediate
- in_ready  out  1  unit accepts this cycle
- in_imm  in  IN_W  raw immediate field
- in_mode  in  2  0=SIGN, 1=ZERO, 2=UPPER, 3=BRANCH
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_data  out  OUT_W  extended immediate at head
- out_mode  out  2  mode tag travelling with out_data
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset: on a clk edge with reset=1:
  - write pointer, read pointer and count clear to 0.
  - out_valid=0, in_ready=0 during the reset cycle, in_ready=1 the cycle after.
  - FIFO storage is not cleared.
  - out_data and out_mode are don't-care while out_valid=0; the bench must not check them then.
- Extension, combinational on the input side, then written into the FIFO:
  - SIGN: {(OUT_W-IN_W){in_imm[IN_W-1]}, in_imm}.
  - ZERO: {(OUT_W-IN_W){1'b0}, in_imm}.
  - UPPER: in_imm placed at bits [OUT_W-1 : OUT_W-IN_W], lower bits zero.
  - BRANCH: SIGN result shifted left by 2, truncated to OUT_W; the two MSBs of the SIGN result are discarded.
- Push: in_valid && in_ready writes the entry at the write pointer and increments the write pointer modulo DEPTH.
- Pop: out_valid && out_ready increments the read pointer modulo DEPTH.
- Flags:
  - in_ready = (count != DEPTH) && !reset.
  - out_valid = (count != 0).
  - Both are registered-state driven; no combinational in→out path.
- Latency: an entry pushed at edge N is visible with out_valid=1 after edge N. Minimum 1 cycle.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - Legal whenever 0 < count < DEPTH.
  - When full, in_ready=0, so only the pop occurs.
- Empty: out_ready is ignored; pointers do not move.
- Full: in_valid is ignored; in_imm and in_mode are not sampled.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble. Order is strict FIFO.
- Reset mid-operation: all buffered entries are discarded. No output is produced from pre-reset data.
- Stability: out_data and out_mode hold stable while out_valid=1 and out_ready=0.
- Illegal in_mode values cannot occur (2-bit field fully decoded).

Optional Feature:
- Macro: IMM_EXTEND_BYPASS_EN.
- When defined:
  - If count==0 and in_valid=1 and out_ready=1, the extended value drives out_data combinationally, with out_valid=1 in the same cycle.
  - Nothing is written to the FIFO.
  - in_ready stays as defined above.
  - Latency becomes 0 in this case.
- When undefined: behaviour is exactly as above, with minimum latency 1 and no input-to-output combinational path.

Decomposition:
- Shared package imm_ext_pkg holds:
  - typedef enum logic [1:0] imm_mode_t {IMM_SIGN, IMM_ZERO, IMM_UPPER, IMM_BRANCH}
  - localparam BRANCH_SHIFT = 2
- One sub-module, imm_extend_core: purely combinational, parametrised on IN_W and OUT_W, maps (imm, mode) to data. The top level holds the FIFO, pointers, count and handshake.

Test Plan:
- SIGN/ZERO sweep, IN_W=16, OUT_W=32, out_ready=1:
  - imm=16'h8001 SIGN → 32'hFFFF8001.
  - imm=16'h8001 ZERO → 32'h00008001.
  - imm=16'h7FFF SIGN → 32'h00007FFF.
  - Each appears exactly 1 cycle after acceptance.
- UPPER/BRANCH:
  - imm=16'h1234 UPPER → 32'h12340000.
  - imm=16'hFFFF BRANCH → 32'hFFFFFFFC.
  - imm=16'h4000 BRANCH → 32'h00010000.
- Backpressure, DEPTH=2, out_ready=0:
  - push 3 immediates: third sees in_ready=0 and count=2.
  - raise out_ready: outputs emerge in order, no duplicates.
- Simultaneous push/pop at count=1 for 10 cycles with random out_ready/in_valid:
  - count stays 1 on each both-fire cycle.
  - Pointer wrap verified; scoreboard matches.
- Reset mid-stream with count=2:
  - next cycle out_valid=0, count=0.
  - First post-reset push (imm=16'h0005 SIGN) emerges as 32'h00000005.
- With IMM_EXTEND_BYPASS_EN, empty FIFO, in_valid=1, out_ready=1, imm=16'hFFFE SIGN:
  - out_valid=1 and out_data=32'hFFFFFFFE in the same cycle.
  - count remains 0.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared types and constants for the immediate-extension datapath.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        IMM_SIGN   = 2'd0,
        IMM_ZERO   = 2'd1,
        IMM_UPPER  = 2'd2,
        IMM_BRANCH = 2'd3
    } imm_mode_t;

    localparam int BRANCH_SHIFT = 2;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extender: maps (imm, mode) to an OUT_W-bit operand.
module imm_extend_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] data
);

    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] zero_ext;
    logic [OUT_W-1:0] upper_ext;

    // IN_W == OUT_W needs its own branch: a zero-width replication is illegal.
    generate
        if (IN_W < OUT_W) begin : g_pad
            assign sign_ext  = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
            assign zero_ext  = {{(OUT_W-IN_W){1'b0}}, imm};
            assign upper_ext = {imm, {(OUT_W-IN_W){1'b0}}};
        end else begin : g_nopad
            assign sign_ext  = imm;
            assign zero_ext  = imm;
            assign upper_ext = imm;
        end
    endgenerate

    always_comb begin
        data = sign_ext;
        case (imm_mode_t'(mode))
            IMM_SIGN:   data = sign_ext;
            IMM_ZERO:   data = zero_ext;
            IMM_UPPER:  data = upper_ext;
            IMM_BRANCH: data = sign_ext << BRANCH_SHIFT;
            default:    data = sign_ext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extender feeding a DEPTH-entry valid/ready FIFO toward the ALU operand mux.
// Optional IMM_EXTEND_BYPASS_EN: an empty FIFO forwards the extended input in the same cycle.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_imm,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic [1:0]               out_mode,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;

    logic [OUT_W-1:0] mem_data [DEPTH];
    logic [1:0]       mem_mode [DEPTH];

    logic [OUT_W-1:0] ext_data;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;

    imm_extend_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .data (ext_data)
    );

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CW'(DEPTH));
    assign in_ready   = !fifo_full && !reset;
    assign pop        = !fifo_empty && out_ready;

`ifdef IMM_EXTEND_BYPASS_EN
    logic bypass;

    // The consumer takes the value directly, so the FIFO is never written.
    assign bypass    = fifo_empty && in_valid && out_ready && !reset;
    assign push      = in_valid && in_ready && !bypass;
    assign out_valid = !fifo_empty || bypass;
    assign out_data  = bypass ? ext_data : mem_data[rd_ptr_reg];
    assign out_mode  = bypass ? in_mode  : mem_mode[rd_ptr_reg];
`else
    assign push      = in_valid && in_ready;
    assign out_valid = !fifo_empty;
    assign out_data  = mem_data[rd_ptr_reg];
    assign out_mode  = mem_mode[rd_ptr_reg];
`endif

    assign count = count_reg;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is deliberately left out of reset; only the pointers define validity.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == AW'(gi))) begin
                    mem_data[gi] <= ext_data;
                    mem_mode[gi] <= in_mode;
                end
            end
        end
    endgenerate

endmodule
